// File: rtl/fir_sample_feeder_if.sv
// AXI-Stream sample bus between the feeder (master) and the FIR core's
// s_axis_data input (slave).
interface fir_sample_feeder_if #(
  parameter int DATA_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers strobed ADC samples in a small FWFT FIFO and
// presents them to the FIR core over AXI-Stream with a real valid/ready
// handshake. Reports buffer level and a sticky overflow flag.
//
// Build option: define FEEDER_OFFSET_BIN_EN when the ADC delivers offset
// binary; the sample MSB is then inverted on entry so the FIR always sees
// two's complement. Left undefined, samples pass through unchanged.
module fir_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [DATA_W-1:0]     sample_in,
  input  logic                  sample_en,
  fir_sample_feeder_if.master   m_axis,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  output logic                  busy
);

  localparam int                DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CAP  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ZERO = '0;
  localparam logic [DEPTH_LOG2:0] ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0]    wr_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr;
  logic [DEPTH_LOG2-1:0]    rd_ptr_nxt;
  logic [DEPTH_LOG2:0]      level;
  logic [DEPTH_LOG2:0]      level_nxt;
  logic signed [DATA_W-1:0] sample_p0;
  logic signed [DATA_W-1:0] tdata_p1;
  logic                     vld_p1;
  logic                     pop;
  logic                     push;
  logic                     full;
  logic                     drop;

  // Map the raw ADC code onto two's complement.
  function automatic logic signed [DATA_W-1:0] to_twos(input logic [DATA_W-1:0] raw);
`ifdef FEEDER_OFFSET_BIN_EN
    return $signed({~raw[DATA_W-1], raw[DATA_W-2:0]});
`else
    return $signed(raw);
`endif
  endfunction

  // ---- stage p0: incoming sample, converted, and FIFO handshake decode ----
  assign sample_p0  = to_twos(sample_in);
  assign pop        = vld_p1 & m_axis.tready;
  assign full       = (level == CAP);
  assign push       = sample_en & (state == RUN) & (!full | pop);
  assign drop       = sample_en & (state == RUN) & full & !pop;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  // Next occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Sample storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_p0;
  end

  // ---- stage p1: registered stream head (tvalid/tdata) and pointers ----
  // The head register always mirrors mem[rd_ptr], so tdata is fed straight
  // from a flop and the oldest sample is visible one edge after its push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      vld_p1 <= (level_nxt != ZERO);
      if (level == ZERO) begin
        if (push) tdata_p1 <= sample_p0;
      end else if (pop) begin
        if (level == ONE) begin
          if (push) tdata_p1 <= sample_p0;
        end else begin
          tdata_p1 <= mem[rd_ptr_nxt];
        end
      end
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Run/drain sequencing; busy is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!run) state <= DRAIN;
          busy <= 1'b1;
        end
        DRAIN: begin
          // A returning run only takes effect once the buffer is empty.
          if (level == ZERO) begin
            state <= run ? RUN : IDLE;
            busy  <= run;
          end else begin
            busy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis.tvalid = vld_p1;
  assign m_axis.tdata  = tdata_p1;
  assign fifo_level    = level;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder (DATA_W=16, DEPTH_LOG2=3).
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_en = 1'b0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic        busy;

  int passed = 0;
  int total  = 0;

  fir_sample_feeder_if #(.DATA_W(16)) m_axis ();

  fir_sample_feeder #(.DATA_W(16), .DEPTH_LOG2(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .sample_in    (sample_in),
    .sample_en    (sample_en),
    .m_axis       (m_axis),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "timeout");
  end

  initial begin
    m_axis.tready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_tvalid", 32'(m_axis.tvalid), 0);
    chk("rst_tdata",  32'(m_axis.tdata), 0);
    chk("rst_level",  32'(fifo_level), 0);
    chk("rst_ovf",    32'(overflow), 0);
    chk("rst_busy",   32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Basic flow
    run = 1'b1;
    m_axis.tready = 1'b1;
    tick();
    chk("run_busy", 32'(busy), 1);
    sample_in = 16'h1234;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("basic_tvalid", 32'(m_axis.tvalid), 1);
    chk("basic_tdata",  32'(m_axis.tdata), 32'h1234);
    chk("basic_level1", 32'(fifo_level), 1);
    tick();
    chk("basic_popped", 32'(m_axis.tvalid), 0);
    chk("basic_level0", 32'(fifo_level), 0);

    // Backpressure
    m_axis.tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      sample_in = 16'(i);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    chk("bp_level", 32'(fifo_level), 8);
    chk("bp_tvalid", 32'(m_axis.tvalid), 1);
    chk("bp_tdata", 32'(m_axis.tdata), 1);
    tick();
    chk("bp_hold_tdata", 32'(m_axis.tdata), 1);
    chk("bp_hold_tvalid", 32'(m_axis.tvalid), 1);
    m_axis.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("bp_stream_tdata", 32'(m_axis.tdata), 32'(i));
      chk("bp_stream_tvalid", 32'(m_axis.tvalid), 1);
      tick();
    end
    chk("bp_empty_level", 32'(fifo_level), 0);
    chk("bp_empty_tvalid", 32'(m_axis.tvalid), 0);

    // Overflow
    m_axis.tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample_in = 16'h0010 + 16'(i);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_head", 32'(m_axis.tdata), 32'h10);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);
    m_axis.tready = 1'b1;
    sample_in = 16'h0099;
    sample_en = 1'b1;
    tick();
    chk("full_pushpop_level", 32'(fifo_level), 8);
    chk("full_pushpop_ovf", 32'(overflow), 0);
    chk("full_pushpop_head", 32'(m_axis.tdata), 32'h11);
    m_axis.tready = 1'b0;
    sample_in = 16'h00AA;
    clr_overflow = 1'b1;
    tick();
    sample_en = 1'b0;
    clr_overflow = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 1);
    chk("set_wins_level", 32'(fifo_level), 8);
    m_axis.tready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("ovf_drain_tdata", 32'(m_axis.tdata), 32'h11 + 32'(i));
      tick();
    end
    chk("ovf_last_tdata", 32'(m_axis.tdata), 32'h99);
    tick();
    chk("ovf_drain_level", 32'(fifo_level), 0);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clear2", 32'(overflow), 0);

    // Drain
    m_axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_in = 16'h0021 + 16'(i);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    run = 1'b0;
    tick();
    chk("drain_busy", 32'(busy), 1);
    sample_in = 16'h0077;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("drain_ignore_level", 32'(fifo_level), 5);
    chk("drain_ignore_ovf", 32'(overflow), 0);
    m_axis.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("drain_tdata", 32'(m_axis.tdata), 32'h21 + 32'(i));
      tick();
    end
    chk("drain_level0", 32'(fifo_level), 0);
    chk("drain_busy_last", 32'(busy), 1);
    tick();
    chk("drain_idle_busy", 32'(busy), 0);
    chk("drain_idle_tvalid", 32'(m_axis.tvalid), 0);

    // Reset mid-stream
    run = 1'b1;
    tick();
    m_axis.tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample_in = 16'h0040 + 16'(i);
      sample_en = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    m_axis.tready = 1'b0;
    chk("mid_level", 32'(fifo_level), 4);
    chk("mid_tvalid", 32'(m_axis.tvalid), 1);
    chk("mid_tdata", 32'(m_axis.tdata), 32'h44);
    chk("mid_ovf", 32'(overflow), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_tvalid", 32'(m_axis.tvalid), 0);
    chk("async_level", 32'(fifo_level), 0);
    chk("async_ovf", 32'(overflow), 0);
    chk("async_busy", 32'(busy), 0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

    // Sample format
    m_axis.tready = 1'b1;
    sample_in = 16'h8000;
    sample_en = 1'b1;
    tick();
`ifdef FEEDER_OFFSET_BIN_EN
    chk("fmt_8000", 32'(m_axis.tdata), 32'h0000);
`else
    chk("fmt_8000", 32'(m_axis.tdata), 32'h8000);
`endif
    sample_in = 16'h0000;
    tick();
`ifdef FEEDER_OFFSET_BIN_EN
    chk("fmt_0000", 32'(m_axis.tdata), 32'h8000);
`else
    chk("fmt_0000", 32'(m_axis.tdata), 32'h0000);
`endif
    sample_in = 16'hFFFF;
    tick();
    sample_en = 1'b0;
`ifdef FEEDER_OFFSET_BIN_EN
    chk("fmt_ffff", 32'(m_axis.tdata), 32'h7FFF);
`else
    chk("fmt_ffff", 32'(m_axis.tdata), 32'hFFFF);
`endif
    chk("fmt_level", 32'(fifo_level), 1);
    tick();
    chk("fmt_empty", 32'(fifo_level), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
